booth_mul_arbiter: RTL and testbench
====================================

# booth_mul_arbiter

Round-robin arbiter and sequencer that shares one 4x4 signed Booth multiplier among NREQ requesters. It picks one pending request, drives the operands and the one-cycle start pulse into the multiplier, and counts the iteration cycles. It then captures the 8-bit product and returns it to the granted requester with a one-cycle done pulse. It sits between the requesting datapath blocks and the single shared multiplier instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- ITER, 4, multiplier iteration cycles after the load cycle (equals operand width)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  NREQ  per-requester request level; held high until matching done
- req_mcd  input  4*NREQ  multiplicand of requester i at bits [4i+3:4i], two's complement
- req_multi  input  4*NREQ  multiplier of requester i at bits [4i+3:4i], two's complement
- gnt  output  NREQ  one-hot grant, high from grant through done cycle
- done  output  NREQ  one-hot, one-cycle pulse to the granted requester
- prod  output  8  registered signed product, valid while done is high, held afterward
- busy  output  1  high in any state other than IDLE
- mul_start  output  1  start/load strobe to the shared multiplier
- mul_mcd  output  4  multiplicand to the multiplier
- mul_multi  output  4  multiplier operand to the multiplier
- mul_prod  input  8  product from the multiplier

## Operation
- States:
  - IDLE: no grant.
  - LOAD: mul_start=1.
  - RUN: counts ITER cycles, mul_start=0.
  - CAPTURE: registers mul_prod.
  - DONE: done pulse.
- IDLE -> LOAD when any req bit is high; otherwise stay.
- LOAD -> RUN unconditionally.
- RUN -> CAPTURE when the iteration counter reaches ITER-1.
- CAPTURE -> DONE unconditionally.
- DONE -> IDLE unconditionally.
- Round-robin arbitration:
  - Search starts at the priority pointer ptr and wraps modulo NREQ; the first set req bit wins.
  - On a grant, ptr <= granted index + 1, wrapping NREQ-1 -> 0.
- Operands of the winner are latched into internal registers on the grant edge and driven on mul_mcd/mul_multi from LOAD through CAPTURE. They are unaffected by later changes on req_mcd/req_multi.
- The iteration counter is log2(ITER)+1 bits wide, cleared in LOAD, incremented in RUN.
- prod is loaded from mul_prod only in CAPTURE; no arithmetic is done in this block.
- Dropping req mid-operation does not abort: the sequence completes and done still pulses to that index.
- mul_mcd/mul_multi hold their last value in IDLE.

## Timing
- Reset values:
  - gnt=0, done=0, prod=8'h00, busy=0, mul_start=0, mul_mcd=0, mul_multi=0.
  - ptr=0, state IDLE, counter=0.
- req is sampled at edge E0 in IDLE. gnt and busy rise after E0.
- mul_start is high for exactly the cycle between E0 and E1; the multiplier loads at E1.
- Multiplier iterates at edges E2..E(ITER+1).
- mul_prod is sampled at E(ITER+2) (CAPTURE).
- done and prod are valid in the cycle after E(ITER+2); gnt and busy fall at E(ITER+3).
- req-to-done latency is ITER+2 cycles; one job costs ITER+4 cycles. The next grant is possible at E(ITER+3) if req is pending, giving one IDLE cycle between jobs.
- Simultaneous requests: exactly one grant; the others wait in order from ptr.
- A requester re-asserting req in its own done cycle is sampled only in IDLE, after ptr has moved past it.
- Asynchronous rst_n low at any point forces reset values immediately; the interrupted job is lost and requesters must re-request.

## Configuration
- BOOTH_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, ptr is unused and held at 0.
- Not defined: round-robin as above.
- Timing and all other behaviour are identical in both builds.

## Test plan
- Single request: req=4'b0001, mcd0=4'b0011 (3), multi0=4'b1110 (-2) -> done[0] pulses 6 cycles after the sampled edge with prod=8'hFA; mul_start high exactly one cycle.
- Corner operands: mcd=4'b1000, multi=4'b1000 (-8*-8) -> prod=8'h40; mcd=4'b0111, multi=4'b1000 -> prod=8'hC8.
- Round-robin: req=4'b1111 held continuously -> grant order 0,1,2,3,0, each job 8 cycles apart. With BOOTH_ARB_FIXED_PRIO_EN -> index 0 is granted repeatedly.
- Operand change after grant: alter req_mcd0 during RUN -> prod still reflects the latched operands.
- Request dropped mid-job: req0 low during RUN -> done[0] still pulses with the correct product; the next job is granted after one IDLE cycle.
- Reset mid-operation: rst_n low during RUN -> outputs return to reset values immediately. After release with req=4'b0100 -> grant index 2, and ptr is back at 0.

Source files
------------

// File: rtl/booth_mul_arbiter.sv
// Round-robin sequencer that shares one 4x4 signed Booth multiplier among NREQ requesters.
// Define BOOTH_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module booth_mul_arbiter #(
    parameter int NREQ = 4,
    parameter int ITER = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [4*NREQ-1:0]    req_mcd,
    input  logic [4*NREQ-1:0]    req_multi,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [7:0]           prod,
    output logic                 busy,
    output logic                 mul_start,
    output logic [3:0]           mul_mcd,
    output logic [3:0]           mul_multi,
    input  logic [7:0]           mul_prod
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(ITER) + 1;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, DONE} state_t;

    state_t          state, nextState;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   winIdx;
    logic [PW-1:0]   nextPtr;
    logic            winValid;
    logic [PW:0]     cand;
    logic [CW-1:0]   iterCnt;
    logic [NREQ-1:0] gntReg;
    logic [3:0]      mcdReg;
    logic [3:0]      multiReg;
    logic [7:0]      prodReg;

    // Scan candidates starting at the search origin; the first requesting index wins.
    always_comb begin
        winValid = 1'b0;
        winIdx   = '0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef BOOTH_ARB_FIXED_PRIO_EN
            cand = (PW+1)'(k);
`else
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ))
                cand = cand - (PW+1)'(NREQ);
`endif
            if (!winValid && req[cand[PW-1:0]]) begin
                winValid = 1'b1;
                winIdx   = cand[PW-1:0];
            end
        end
        nextPtr = (winIdx == PW'(NREQ-1)) ? '0 : winIdx + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (winValid) nextState = LOAD;
            LOAD:    nextState = RUN;
            RUN:     if (iterCnt == CW'(ITER-1)) nextState = CAPTURE;
            CAPTURE: nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Operands are captured on the grant edge so requesters may change their buses mid-job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            gntReg   <= '0;
            mcdReg   <= '0;
            multiReg <= '0;
            iterCnt  <= '0;
            prodReg  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (winValid) begin
                        gntReg   <= NREQ'(1) << winIdx;
                        mcdReg   <= req_mcd[4*winIdx +: 4];
                        multiReg <= req_multi[4*winIdx +: 4];
`ifdef BOOTH_ARB_FIXED_PRIO_EN
                        ptr      <= '0;
`else
                        ptr      <= nextPtr;
`endif
                    end
                end
                LOAD:    iterCnt <= '0;
                RUN:     iterCnt <= iterCnt + CW'(1);
                CAPTURE: prodReg <= mul_prod;
                DONE:    gntReg  <= '0;
                default: ;
            endcase
        end
    end

    assign gnt       = gntReg;
    assign done      = (state == DONE) ? gntReg : '0;
    assign prod      = prodReg;
    assign busy      = (state != IDLE);
    assign mul_start = (state == LOAD);
    assign mul_mcd   = mcdReg;
    assign mul_multi = multiReg;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench for booth_mul_arbiter with a behavioural iterating multiplier model.
// Expected grant order follows BOOTH_ARB_FIXED_PRIO_EN when that macro is defined.
module tb_booth_mul_arbiter;

    localparam int NREQ = 4;
    localparam int ITER = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] req_mcd;
    logic [4*NREQ-1:0] req_multi;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [7:0]        prod;
    logic              busy;
    logic              mul_start;
    logic [3:0]        mul_mcd;
    logic [3:0]        mul_multi;
    logic [7:0]        mul_prod;

    int checks;
    int fails;

    booth_mul_arbiter #(.NREQ(NREQ), .ITER(ITER)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_mcd(req_mcd), .req_multi(req_multi),
        .gnt(gnt), .done(done), .prod(prod), .busy(busy), .mul_start(mul_start),
        .mul_mcd(mul_mcd), .mul_multi(mul_multi), .mul_prod(mul_prod)
    );

    always #5 clk = ~clk;

    // Shared multiplier stand-in: loads on start, finishes after ITER iteration edges.
    logic [7:0]        mulAcc = 8'h00;
    int                mulCnt = 0;
    logic signed [7:0] mcdExt;
    logic signed [7:0] multiExt;
    assign mcdExt   = {{4{mul_mcd[3]}}, mul_mcd};
    assign multiExt = {{4{mul_multi[3]}}, mul_multi};
    assign mul_prod = mulAcc;

    always @(posedge clk) begin
        if (mul_start)
            mulCnt <= ITER;
        else if (mulCnt != 0) begin
            mulCnt <= mulCnt - 1;
            if (mulCnt == 1)
                mulAcc <= mcdExt * multiExt;
        end
    end

    typedef struct {
        int         idx;
        logic [3:0] mcd;
        logic [3:0] multi;
        logic [7:0] expProd;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r);
        req = r;
    endtask

    task automatic setOperands(input int idx, input logic [3:0] mcd, input logic [3:0] multi);
        req_mcd[4*idx +: 4]   = mcd;
        req_multi[4*idx +: 4] = multi;
    endtask

    // Waits (bounded) for a done pulse, sampling on falling edges.
    task automatic waitJob(output int cycles, output int doneIdx, output int starts,
                           output logic [NREQ-1:0] firstGnt);
        cycles   = 0;
        doneIdx  = -1;
        starts   = 0;
        firstGnt = '0;
        while (cycles < 40 && doneIdx < 0) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) firstGnt = gnt;
            if (mul_start) starts++;
            for (int i = 0; i < NREQ; i++)
                if (done[i]) doneIdx = i;
        end
        if (doneIdx < 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL jobTimeout: actual no done after %0d cycles, required done pulse", cycles);
        end
    endtask

    int               cyc, idx, starts;
    logic [NREQ-1:0]  fg;
    int               expOrder[5];

    initial begin
        checks    = 0;
        fails     = 0;
        rst_n     = 1'b0;
        req       = '0;
        req_mcd   = '0;
        req_multi = '0;

        vecs[0] = '{0, 4'b0011, 4'b1110, 8'hFA};
        vecs[1] = '{1, 4'b1000, 4'b1000, 8'h40};
        vecs[2] = '{2, 4'b0111, 4'b1000, 8'hC8};
        vecs[3] = '{3, 4'b1111, 4'b1111, 8'h01};
        vecs[4] = '{1, 4'b0101, 4'b0011, 8'h0F};
        vecs[5] = '{2, 4'b1001, 4'b0111, 8'hCF};
        vecs[6] = '{0, 4'b0000, 4'b0101, 8'h00};

        repeat (2) @(negedge clk);
        checkOutput("resetOutputs", {gnt, done, prod, busy, mul_start, mul_mcd, mul_multi}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idleAfterReset", {gnt, busy}, 0);

        for (int v = 0; v < 7; v++) begin
            setOperands(vecs[v].idx, vecs[v].mcd, vecs[v].multi);
            applyStimulus(NREQ'(1) << vecs[v].idx);
            waitJob(cyc, idx, starts, fg);
            checkOutput($sformatf("vec%0d doneIdx", v), idx, vecs[v].idx);
            checkOutput($sformatf("vec%0d prod", v), prod, vecs[v].expProd);
            checkOutput($sformatf("vec%0d latency", v), cyc, ITER + 3);
            checkOutput($sformatf("vec%0d startPulses", v), starts, 1);
            checkOutput($sformatf("vec%0d firstGnt", v), fg, NREQ'(1) << vecs[v].idx);
            applyStimulus('0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d released", v), {gnt, done, busy}, 0);
            checkOutput($sformatf("vec%0d prodHeld", v), prod, vecs[v].expProd);
        end

        // Operand bus changes during RUN must not reach the multiplier.
        setOperands(3, 4'b0110, 4'b1101);
        applyStimulus(4'b1000);
        repeat (3) @(negedge clk);
        setOperands(3, 4'b0111, 4'b0001);
        @(negedge clk);
        checkOutput("latchedMcd", mul_mcd, 4'h6);
        waitJob(cyc, idx, starts, fg);
        checkOutput("latched doneIdx", idx, 3);
        checkOutput("latched prod", prod, 8'hEE);
        applyStimulus('0);
        @(negedge clk);

        // Requester 0 drops mid-job while requester 1 starts waiting.
        setOperands(0, 4'b0100, 4'b0100);
        setOperands(1, 4'b0010, 4'b1111);
        applyStimulus(4'b0001);
        repeat (3) @(negedge clk);
        applyStimulus(4'b0010);
        waitJob(cyc, idx, starts, fg);
        checkOutput("dropped doneIdx", idx, 0);
        checkOutput("dropped prod", prod, 8'h10);
        waitJob(cyc, idx, starts, fg);
        checkOutput("followOn idleGap", fg, 0);
        checkOutput("followOn spacing", cyc, ITER + 4);
        checkOutput("followOn doneIdx", idx, 1);
        checkOutput("followOn prod", prod, 8'hFE);
        applyStimulus('0);
        @(negedge clk);

        // Asynchronous reset in the middle of RUN, with the pointer away from 0.
        setOperands(1, 4'b0011, 4'b0011);
        applyStimulus(4'b0010);
        repeat (3) @(negedge clk);
        checkOutput("busyBeforeReset", busy, 1);
        #2 rst_n = 1'b0;
        #1 checkOutput("resetMidJob", {gnt, done, prod, busy, mul_start, mul_mcd, mul_multi}, 0);
        for (int i = 0; i < NREQ; i++) setOperands(i, 4'(i + 1), 4'b0010);
        applyStimulus(4'b1111);
        @(negedge clk);
        checkOutput("heldInReset", {gnt, busy}, 0);
        rst_n = 1'b1;

`ifdef BOOTH_ARB_FIXED_PRIO_EN
        expOrder = '{0, 0, 0, 0, 0};
`else
        expOrder = '{0, 1, 2, 3, 0};
`endif
        for (int j = 0; j < 5; j++) begin
            waitJob(cyc, idx, starts, fg);
            checkOutput($sformatf("arb%0d doneIdx", j), idx, expOrder[j]);
            checkOutput($sformatf("arb%0d prod", j), prod, 8'(2 * (expOrder[j] + 1)));
            checkOutput($sformatf("arb%0d spacing", j), cyc, (j == 0) ? ITER + 3 : ITER + 4);
        end
        applyStimulus('0);
        @(negedge clk);

        // Fresh reset, then a lone request from index 2 followed by a mixed pending set.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b0100);
        waitJob(cyc, idx, starts, fg);
        checkOutput("postReset firstGnt", fg, 4'b0100);
        checkOutput("postReset doneIdx", idx, 2);
        checkOutput("postReset prod", prod, 8'h06);
        applyStimulus(4'b1011);
        waitJob(cyc, idx, starts, fg);
`ifdef BOOTH_ARB_FIXED_PRIO_EN
        checkOutput("afterTwo doneIdx", idx, 0);
        checkOutput("afterTwo prod", prod, 8'h02);
`else
        checkOutput("afterTwo doneIdx", idx, 3);
        checkOutput("afterTwo prod", prod, 8'h08);
`endif
        applyStimulus('0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
